// File: rtl/timer_prescaler.sv
// Single-clock timer prescaler: produces a one-pclk tick and a registered divided clock.
// Ratio changes are deferred to the period wrap so every period completes with a single D.
module timer_prescaler #(
    parameter int CKS_W = 2,
    parameter int DIV_W = 8
) (
    input  logic             pclk,
    input  logic             presetn,
    input  logic             en,
    input  logic             clr,
    input  logic             mode,
    input  logic [CKS_W-1:0] cks,
    input  logic [DIV_W-1:0] div_val,
    output logic             tick,
    output logic             clk_out,
    output logic             pend,
    output logic [DIV_W-1:0] cnt_o
);

    typedef logic [DIV_W:0] ratio_t;

    logic             mode_a;
    logic [CKS_W-1:0] cks_a;
    logic [DIV_W-1:0] div_a;
    logic [DIV_W-1:0] cnt;

    logic [DIV_W-1:0] cnt_nxt;
    logic             tick_nxt;
    logic             clk_nxt;
    logic             load;
    logic             wrap;
    ratio_t           d_act;
    ratio_t           d_live;
    ratio_t           d_next;

    function automatic ratio_t ratio(input logic             m,
                                     input logic [CKS_W-1:0] c,
                                     input logic [DIV_W-1:0] d);
        logic [CKS_W:0] sh;
        sh = {1'b0, c} + (CKS_W+1)'(1);
        if (m)
            return {1'b0, d} + ratio_t'(1);
        return ratio_t'(1) << sh;
    endfunction

    assign d_act  = ratio(mode_a, cks_a, div_a);
    assign d_live = ratio(mode, cks, div_val);
    assign pend   = {mode, cks, div_val} != {mode_a, cks_a, div_a};

    // >= rather than == so a ratio shrunk while idle below the held count still wraps promptly.
    assign wrap   = {1'b0, cnt} >= (d_act - ratio_t'(1));

    // NOTE: every variable gets a default before the branches, so no path leaves one unassigned
    // and no latch is inferred.
    always_comb begin
        cnt_nxt  = cnt;
        tick_nxt = 1'b0;
        clk_nxt  = clk_out;
        load     = 1'b0;
        d_next   = d_act;

        if (clr) begin
            cnt_nxt = '0;
            load    = 1'b1;
        end else if (en) begin
            if (wrap) begin
                cnt_nxt  = '0;
                tick_nxt = 1'b1;
                load     = 1'b1;
            end else begin
                cnt_nxt = cnt + DIV_W'(1);
            end
        end else begin
            load = 1'b1;
        end

        if (load)
            d_next = d_live;

        // High for floor(D/2) counts, which also keeps clk_out low forever when D=1.
        if (clr || en)
            clk_nxt = {1'b0, cnt_nxt} < (d_next >> 1);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample the same
    // pre-edge values regardless of statement order.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            cnt     <= '0;
            tick    <= 1'b0;
            clk_out <= 1'b0;
            mode_a  <= 1'b0;
            cks_a   <= '0;
            div_a   <= '0;
        end else begin
            cnt     <= cnt_nxt;
            tick    <= tick_nxt;
            clk_out <= clk_nxt;
            if (load) begin
                mode_a <= mode;
                cks_a  <= cks;
                div_a  <= div_val;
            end
        end
    end

    assign cnt_o = cnt;

endmodule

// File: tb/tb_timer_prescaler.sv
// Bench for timer_prescaler: stimulus drives a period-level reference model and queues the
// expected outputs; an independent monitor compares them against the DUT every negedge.
module tb_timer_prescaler;

    logic       pclk;
    logic       presetn;
    logic       en;
    logic       clr;
    logic       mode;
    logic [1:0] cks;
    logic [7:0] div_val;
    logic       tick;
    logic       clk_out;
    logic       pend;
    logic [7:0] cnt_o;

    timer_prescaler #(.CKS_W(2), .DIV_W(8)) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .en      (en),
        .clr     (clr),
        .mode    (mode),
        .cks     (cks),
        .div_val (div_val),
        .tick    (tick),
        .clk_out (clk_out),
        .pend    (pend),
        .cnt_o   (cnt_o)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    typedef struct {
        int tick;
        int clk;
        int cnt;
        int pend;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference state: position in the period plus the ratio settings in force.
    int m_cnt, m_tick, m_clk, m_mode, m_cks, m_div;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int period_of(input int mo, input int c, input int dv);
        return mo ? dv + 1 : 2 ** (c + 1);
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_tick = 0; m_clk = 0;
        m_mode = 0; m_cks = 0; m_div = 0;
    endtask

    // Advance the model by one pclk edge using the inputs that were present at that edge.
    task automatic model_step();
        int d;
        if (!presetn) begin
            model_reset();
        end else if (clr) begin
            m_mode = mode; m_cks = cks; m_div = div_val;
            m_cnt  = 0;
            m_tick = 0;
            m_clk  = (period_of(m_mode, m_cks, m_div) >= 2);
        end else if (en) begin
            d = period_of(m_mode, m_cks, m_div);
            if (m_cnt >= d - 1) begin
                m_cnt  = 0;
                m_tick = 1;
                m_mode = mode; m_cks = cks; m_div = div_val;
            end else begin
                m_cnt  = m_cnt + 1;
                m_tick = 0;
            end
            m_clk = (m_cnt < period_of(m_mode, m_cks, m_div) / 2);
        end else begin
            m_tick = 0;
            m_mode = mode; m_cks = cks; m_div = div_val;
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.tick = m_tick;
        e.clk  = m_clk;
        e.cnt  = m_cnt;
        e.pend = (mode != m_mode) || (cks != m_cks) || (div_val != m_div);
        sb.push_back(e);
    endtask

    // One pclk: the edge consumes the current inputs, then the next inputs are applied.
    task automatic cycle(input bit n_en, input bit n_clr, input bit n_mode,
                         input int n_cks, input int n_div);
        @(posedge pclk);
        #1;
        model_step();
        en      = n_en;
        clr     = n_clr;
        mode    = n_mode;
        cks     = n_cks[1:0];
        div_val = n_div[7:0];
        push_exp();
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++)
            cycle(en, clr, mode, cks, div_val);
    endtask

    task automatic run_until_cnt(input int target, input int budget);
        int k;
        k = 0;
        while (m_cnt != target && k < budget) begin
            cycle(en, clr, mode, cks, div_val);
            k++;
        end
        check("reach_cnt_within_budget", (m_cnt == target), 1);
    endtask

    // Async reset between edges: outputs must clear without waiting for pclk.
    task automatic mid_reset();
        @(negedge pclk);
        #2;
        presetn = 1'b0;
        #1;
        check("async_rst_tick", tick, 0);
        check("async_rst_clk_out", clk_out, 0);
        check("async_rst_cnt", cnt_o, 0);
        model_reset();
        cycle(1'b1, 1'b0, 1'b0, 0, 0);
        presetn = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge pclk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("tick", tick, e.tick);
                check("clk_out", clk_out, e.clk);
                check("cnt_o", cnt_o, e.cnt);
                check("pend", pend, e.pend);
            end
        end
    end

    initial begin : stimulus
        presetn = 1'b0;
        en      = 1'b1;
        clr     = 1'b0;
        mode    = 1'b0;
        cks     = 2'd0;
        div_val = 8'd0;
        model_reset();

        // Reset state, then D=2 counting.
        cycle(1'b1, 1'b0, 1'b0, 0, 0);
        cycle(1'b1, 1'b0, 1'b0, 0, 0);
        presetn = 1'b1;
        hold(8);

        // Ratio change to D=16 at cnt=0: pend for two cycles, then 8 high / 8 low.
        run_until_cnt(0, 4);
        cycle(1'b1, 1'b0, 1'b0, 3, 0);
        hold(40);

        // Linear divide by 5, then by 1.
        cycle(1'b1, 1'b0, 1'b1, 3, 4);
        hold(30);
        cycle(1'b1, 1'b0, 1'b1, 3, 0);
        hold(12);

        // Freeze at cnt=5 with D=16, change ratio while idle, resume.
        cycle(1'b1, 1'b0, 1'b0, 3, 0);
        run_until_cnt(5, 40);
        cycle(1'b0, 1'b0, 1'b0, 3, 0);
        hold(10);
        cycle(1'b0, 1'b0, 1'b0, 2, 0);
        hold(3);
        cycle(1'b1, 1'b0, 1'b0, 2, 0);
        hold(20);

        // Clear at cnt=9 loads a new ratio immediately.
        cycle(1'b1, 1'b0, 1'b0, 3, 0);
        run_until_cnt(9, 60);
        cycle(1'b1, 1'b1, 1'b1, 3, 6);
        cycle(1'b1, 1'b0, 1'b1, 3, 6);
        hold(20);

        // Async reset in the middle of a D=16 period.
        cycle(1'b1, 1'b0, 1'b0, 3, 0);
        run_until_cnt(7, 60);
        mid_reset();
        hold(8);

        // Randomized traffic.
        for (int i = 0; i < 2500; i++) begin
            bit ne, nc, nm;
            int nk, nd;
            ne = ($urandom_range(0, 9) != 0);
            nc = ($urandom_range(0, 39) == 0);
            nm = mode;
            nk = cks;
            nd = div_val;
            if ($urandom_range(0, 11) == 0) begin
                nm = $urandom_range(0, 1);
                nk = $urandom_range(0, 3);
                nd = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 12);
            end
            if (i % 700 == 350)
                mid_reset();
            else
                cycle(ne, nc, nm, nk, nd);
        end

        @(negedge pclk);
        #1;
        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
